qspi_ram_arbiter: RTL and testbench
===================================

# qspi_ram_arbiter

Shares the single QSPI PSRAM controller between two requesters: port 0 (CPU fetch/load-store, high priority) and port 1 (SPI-screen framebuffer streaming, low priority). It arbitrates with a starvation guard, latches one burst request per grant, and sequences the controller through start, byte transfer and stop. It counts burst bytes and reports per-port completion. It sits between the CPU/display blocks and the QSPI RAM controller that drives the ram_clk/ram_csn/ram_io pins.

## Interface
- ADDR_W, 24, byte address width of the PSRAM.
- MAX_WAIT, 8, number of consecutive arbitration losses by port 1 after which port 1 wins over port 0; range 1..255.

Ports (`<i>` is 0 or 1):
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- rq<i>_req  in  1  request; held until rq<i>_done.
- rq<i>_addr  in  ADDR_W  burst start address; sampled at grant.
- rq<i>_wr  in  1  1 = write burst, 0 = read burst; sampled at grant.
- rq<i>_len  in  8  burst length minus 1 (0 → 1 byte, 255 → 256 bytes); sampled at grant.
- rq<i>_wdata  in  8  current write byte.
- rq<i>_grant  out  1  port owns the RAM.
- rq<i>_wready  out  1  write byte consumed this cycle.
- rq<i>_rdata  out  8  read byte.
- rq<i>_rvalid  out  1  rq<i>_rdata valid, one-cycle pulse.
- rq<i>_done  out  1  burst complete, one-cycle pulse.
- ram_start  out  1  one-cycle pulse opening a transaction.
- ram_addr  out  ADDR_W  latched address.
- ram_wr  out  1  latched direction.
- ram_wdata  out  8  write byte to controller.
- ram_stop  out  1  one-cycle pulse that ends the burst (deasserts CS).
- ram_busy  in  1  controller has CS asserted / not idle.
- ram_wnext  in  1  controller consumed ram_wdata.
- ram_rdata  in  8  byte from controller.
- ram_rvalid  in  1  ram_rdata valid.

## Operation
- States: IDLE, START, XFER, STOP.
- IDLE: arbitrate only when ram_busy=0 and at least one req is high.
  - Port 1 wins if rq0_req=0, or if wait_cnt≥MAX_WAIT.
  - Otherwise port 0 wins.
  - On a win, latch addr, wr and len into registers, set byte counter = len, raise grant, go to START.
- wait_cnt (8 bits, saturating):
  - increments on each grant to port 0 while rq1_req=1;
  - clears on each grant to port 1.
- START: ram_start=1 for one cycle, with ram_addr and ram_wr valid. Go to XFER.
- XFER, byte event: ram_wnext when wr=1, ram_rvalid when wr=0.
  - Each byte event decrements the counter.
  - A byte event with counter=0 goes to STOP.
- Write path:
  - ram_wdata = granted port's rq_wdata (combinational).
  - rq<g>_wready = ram_wnext, combinational, in XFER only.
- Read path: on ram_rvalid in XFER with wr=0, the next cycle has rq<g>_rdata=ram_rdata and rq<g>_rvalid=1.
- Ignored events:
  - ram_rvalid during a write;
  - ram_wnext during a read;
  - any byte event outside XFER.
- STOP:
  - ram_stop=1 on the first STOP cycle only.
  - Stay in STOP while ram_busy=1.
  - When ram_busy=0 (and not on the first STOP cycle): pulse rq<g>_done, clear grant, go to IDLE.
- Requests:
  - rq_req dropping mid-burst has no effect; the burst completes.
  - rq_req still high after done starts a new arbitration.
- Non-granted port: wready, rvalid and done stay 0.

## Timing
- Reset values (async assert, all outputs): 0.
  - ram_addr, ram_wdata, rq rdata = 0.
  - State IDLE, wait_cnt=0, counter=0.
- Reset is asynchronous and may assert at any point mid-burst.
  - No done pulse is emitted for the aborted burst.
  - Recovery relies on the controller being reset by the same rst_n.
- Grant latency:
  - Request high at edge E0 in IDLE → grant and ram_start high in the cycle after E0.
  - ram_start low after E1.
- Read latency: ram_rvalid → rq_rvalid is exactly 1 cycle.
- Write handshake: ram_wnext → rq_wready is 0 cycles.
- Last byte event at edge En:
  - ram_stop high in the cycle after En.
  - done no earlier than 2 cycles after En.
- Turnaround: at least one IDLE cycle between done and the next ram_start, so minimum ram_start spacing = len+5 cycles.

## Test plan
- Single read: port 0 reads addr 0x000123, len=0. Required:
  - ram_start one cycle with ram_addr=0x000123, ram_wr=0.
  - ram_rvalid with 0xA5 → rq0_rvalid and rdata=0xA5 one cycle later.
  - ram_stop pulse, then rq0_done after ram_busy falls.
- Write burst: port 1 writes len=3 with bytes 0x11,0x22,0x33,0x44 on four ram_wnext pulses. Required:
  - ram_wdata matches each byte; rq1_wready mirrors ram_wnext.
  - ram_stop in the cycle after the 4th pulse.
  - A 5th ram_wnext is ignored.
- Starvation, MAX_WAIT=8, both ports requesting continuously. Required:
  - Grants go to port 0 eight times, then the 9th grant goes to port 1, then port 0 again.
- Busy gating: ram_busy held 1 in IDLE with rq0_req=1. Required: no grant until ram_busy=0, then grant the next cycle.
- Full length with extra data: port 0 reads len=255. Required:
  - Exactly 256 rq0_rvalid pulses.
  - A 257th ram_rvalid during STOP is not forwarded.
- Reset mid-burst: assert rst_n=0 during XFER. Required:
  - All outputs 0 immediately and no done pulse.
  - After release, a fresh port 1 request is granted normally.

Source files
------------

// File: rtl/qspi_ram_arbiter.sv
// Shares one QSPI PSRAM controller between a priority CPU port and a starvation-guarded display port.
// Grant and ram_start one cycle after arbitration; reads forwarded one cycle late, write ready is combinational.
module qspi_ram_arbiter #(
   parameter int ADDR_W   = 24,
   parameter int MAX_WAIT = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rq0_req,
   input  logic [ADDR_W-1:0] rq0_addr,
   input  logic              rq0_wr,
   input  logic [7:0]        rq0_len,
   input  logic [7:0]        rq0_wdata,
   output logic              rq0_grant,
   output logic              rq0_wready,
   output logic [7:0]        rq0_rdata,
   output logic              rq0_rvalid,
   output logic              rq0_done,
   input  logic              rq1_req,
   input  logic [ADDR_W-1:0] rq1_addr,
   input  logic              rq1_wr,
   input  logic [7:0]        rq1_len,
   input  logic [7:0]        rq1_wdata,
   output logic              rq1_grant,
   output logic              rq1_wready,
   output logic [7:0]        rq1_rdata,
   output logic              rq1_rvalid,
   output logic              rq1_done,
   output logic              ram_start,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_wr,
   output logic [7:0]        ram_wdata,
   output logic              ram_stop,
   input  logic              ram_busy,
   input  logic              ram_wnext,
   input  logic [7:0]        ram_rdata,
   input  logic              ram_rvalid
);
   typedef enum logic [1:0] {IDLE, START, XFER, STOP} state_t;

   state_t            state, state_nxt;
   logic              owner;
   logic              granted;
   logic [ADDR_W-1:0] addr_q;
   logic              wr_q;
   logic [7:0]        cnt;
   logic [7:0]        wait_cnt;
   logic              stop_first;
   logic              rvalid_q;
   logic [7:0]        rdata_q;
   logic              arb_go;
   logic              pick1;
   logic              byte_evt;
   logic              fin;
   logic              wr_ack;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      arb_go    = 1'b0;
      byte_evt  = 1'b0;
      fin       = 1'b0;
      pick1     = rq1_req && (!rq0_req || (wait_cnt >= 8'(MAX_WAIT)));
      case (state)
         IDLE: begin
            if (!ram_busy && (rq0_req || rq1_req)) begin
               arb_go    = 1'b1;
               state_nxt = START;
            end
         end
         START: state_nxt = XFER;
         XFER: begin
            // only the event type matching the latched direction counts as a byte
            byte_evt = wr_q ? ram_wnext : ram_rvalid;
            if (byte_evt && (cnt == 8'd0)) state_nxt = STOP;
         end
         STOP: begin
            if (!stop_first && !ram_busy) begin
               fin       = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner      <= 1'b0;
         granted    <= 1'b0;
         addr_q     <= '0;
         wr_q       <= 1'b0;
         cnt        <= 8'd0;
         wait_cnt   <= 8'd0;
         stop_first <= 1'b0;
         rvalid_q   <= 1'b0;
         rdata_q    <= 8'd0;
      end else begin
         stop_first <= (state == XFER);
         rvalid_q   <= byte_evt && !wr_q;
         if (byte_evt && !wr_q) rdata_q <= ram_rdata;
         if (arb_go) begin
            owner   <= pick1;
            granted <= 1'b1;
            addr_q  <= pick1 ? rq1_addr : rq0_addr;
            wr_q    <= pick1 ? rq1_wr : rq0_wr;
            cnt     <= pick1 ? rq1_len : rq0_len;
            if (pick1)
               wait_cnt <= 8'd0;
            else if (rq1_req && (wait_cnt != 8'hFF))
               wait_cnt <= wait_cnt + 8'd1;
         end else if (byte_evt && (cnt != 8'd0)) begin
            cnt <= cnt - 8'd1;
         end
         if (fin) granted <= 1'b0;
      end
   end

   assign wr_ack    = (state == XFER) && wr_q && ram_wnext;
   assign ram_start = (state == START);
   assign ram_stop  = (state == STOP) && stop_first;
   assign ram_addr  = addr_q;
   assign ram_wr    = wr_q;
   assign ram_wdata = !granted ? 8'd0 : (owner ? rq1_wdata : rq0_wdata);

   assign rq0_grant  = granted && !owner;
   assign rq1_grant  = granted && owner;
   assign rq0_wready = wr_ack && !owner;
   assign rq1_wready = wr_ack && owner;
   assign rq0_rvalid = rvalid_q && !owner;
   assign rq1_rvalid = rvalid_q && owner;
   assign rq0_done   = fin && !owner;
   assign rq1_done   = fin && owner;
   assign rq0_rdata  = rdata_q;
   assign rq1_rdata  = rdata_q;
endmodule

// File: tb/tb_qspi_ram_arbiter.sv
// Bench for qspi_ram_arbiter: a cycle-stepped PSRAM controller stand-in drives the RAM side while a
// transaction-level model predicts the winner of each arbitration, the latched burst and its data.
module tb_qspi_ram_arbiter;
   localparam int ADDR_W   = 24;
   localparam int MAX_WAIT = 8;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              rq0_req = 1'b0, rq0_wr = 1'b0, rq1_req = 1'b0, rq1_wr = 1'b0;
   logic [ADDR_W-1:0] rq0_addr = '0, rq1_addr = '0;
   logic [7:0]        rq0_len = 8'd0, rq0_wdata = 8'd0, rq1_len = 8'd0, rq1_wdata = 8'd0;
   logic              rq0_grant, rq0_wready, rq0_rvalid, rq0_done;
   logic              rq1_grant, rq1_wready, rq1_rvalid, rq1_done;
   logic [7:0]        rq0_rdata, rq1_rdata;
   logic              ram_start, ram_wr, ram_stop;
   logic [ADDR_W-1:0] ram_addr;
   logic [7:0]        ram_wdata;
   logic              ram_busy = 1'b0, ram_wnext = 1'b0, ram_rvalid = 1'b0;
   logic [7:0]        ram_rdata = 8'd0;

   int checks = 0;
   int failures = 0;
   int model_wait = 0;
   bit fixed_data = 1'b0;

   always #5 clk = ~clk;

   qspi_ram_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .rst_n(rst_n),
      .rq0_req(rq0_req), .rq0_addr(rq0_addr), .rq0_wr(rq0_wr), .rq0_len(rq0_len), .rq0_wdata(rq0_wdata),
      .rq0_grant(rq0_grant), .rq0_wready(rq0_wready), .rq0_rdata(rq0_rdata), .rq0_rvalid(rq0_rvalid),
      .rq0_done(rq0_done),
      .rq1_req(rq1_req), .rq1_addr(rq1_addr), .rq1_wr(rq1_wr), .rq1_len(rq1_len), .rq1_wdata(rq1_wdata),
      .rq1_grant(rq1_grant), .rq1_wready(rq1_wready), .rq1_rdata(rq1_rdata), .rq1_rvalid(rq1_rvalid),
      .rq1_done(rq1_done),
      .ram_start(ram_start), .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_wdata(ram_wdata),
      .ram_stop(ram_stop), .ram_busy(ram_busy), .ram_wnext(ram_wnext), .ram_rdata(ram_rdata),
      .ram_rvalid(ram_rvalid)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic gnt(input int p);
      return (p != 0) ? rq1_grant : rq0_grant;
   endfunction
   function automatic logic wrdy(input int p);
      return (p != 0) ? rq1_wready : rq0_wready;
   endfunction
   function automatic logic rvld(input int p);
      return (p != 0) ? rq1_rvalid : rq0_rvalid;
   endfunction
   function automatic logic done_o(input int p);
      return (p != 0) ? rq1_done : rq0_done;
   endfunction

   task automatic check_rd(input int p, input bit pend, input logic [7:0] pdat, inout int rv_cnt);
      check_eq("rvalid_own", rvld(p), pend);
      check_eq("rvalid_other", rvld(1 - p), 0);
      if (pend) check_eq("rdata", (p != 0) ? rq1_rdata : rq0_rdata, pdat);
      if (rvld(p)) rv_cnt++;
   endtask

   // Runs one burst end to end; entered with the arbiter idle, returns on the idle cycle after done.
   task automatic do_burst(input int p, input logic [ADDR_W-1:0] a, input logic w, input int len,
                           input int gap_max, input bit extra, input int hold, output int wait_n);
      int n, gap, rv_cnt;
      bit evt, pend;
      logic [7:0] b, pdat;
      n = 0;
      @(negedge clk);
      while (!(rq0_grant || rq1_grant) && n < 40) begin
         next_cyc();
         @(negedge clk);
         n++;
      end
      wait_n = n;
      check_eq("grant_timeout", n < 40, 1);
      check_eq("grant_port", {rq1_grant, rq0_grant}, (p != 0) ? 2'b10 : 2'b01);
      check_eq("ram_start", ram_start, 1);
      check_eq("ram_addr", ram_addr, a);
      check_eq("ram_wr", ram_wr, w);
      next_cyc();
      ram_busy = 1'b1;
      // request inputs wander after grant; the burst must keep its latched shape
      rq0_addr = 24'($urandom); rq1_addr = 24'($urandom);
      rq0_len = 8'($urandom); rq1_len = 8'($urandom);
      rq0_wr = 1'($urandom); rq1_wr = 1'($urandom);
      if ($urandom_range(1, 0) == 1) begin
         if (p != 0) rq1_req = 1'b0; else rq0_req = 1'b0;
      end
      pend = 1'b0; pdat = 8'd0; rv_cnt = 0;
      for (int i = 0; i <= len; i++) begin
         gap = $urandom_range(gap_max, 0);
         for (int g = 0; g <= gap; g++) begin
            evt = (g == gap);
            b = fixed_data ? (w ? 8'((i + 1) * 17) : 8'(165 + i)) : 8'($urandom);
            rq0_wdata = 8'($urandom); rq1_wdata = 8'($urandom);
            if (p != 0) rq1_wdata = b; else rq0_wdata = b;
            ram_rdata = b;
            ram_wnext = evt ? w : (($urandom_range(3, 0) == 0) && !w);
            ram_rvalid = evt ? !w : (($urandom_range(3, 0) == 0) && w);
            @(negedge clk);
            check_rd(p, pend, pdat, rv_cnt);
            check_eq("wready_own", wrdy(p), evt && w);
            check_eq("wready_other", wrdy(1 - p), 0);
            if (evt && w) check_eq("ram_wdata", ram_wdata, b);
            check_eq("stop_early", ram_stop, 0);
            check_eq("done_early", rq0_done | rq1_done, 0);
            pend = evt && !w;
            pdat = b;
            next_cyc();
         end
      end
      ram_wnext = extra && w;
      ram_rvalid = extra && !w;
      ram_rdata = 8'h5A;
      @(negedge clk);
      check_rd(p, pend, pdat, rv_cnt);
      check_eq("ram_stop", ram_stop, 1);
      check_eq("wready_in_stop", rq0_wready | rq1_wready, 0);
      check_eq("done_first_stop", rq0_done | rq1_done, 0);
      next_cyc();
      ram_wnext = 1'b0;
      ram_rvalid = 1'b0;
      n = 0;
      ram_busy = (hold > 0);
      @(negedge clk);
      check_rd(p, 1'b0, 8'd0, rv_cnt);
      check_eq("stop_one_cycle", ram_stop, 0);
      while (ram_busy && n < 8) begin
         check_eq("done_while_busy", rq0_done | rq1_done, 0);
         next_cyc();
         n++;
         ram_busy = (n < hold);
         @(negedge clk);
      end
      check_eq("done_own", done_o(p), 1);
      check_eq("done_other", done_o(1 - p), 0);
      check_eq("grant_at_done", gnt(p), 1);
      check_eq("rvalid_count", rv_cnt, w ? 0 : len + 1);
      next_cyc();
      @(negedge clk);
      check_eq("idle_gap", {rq0_grant, rq1_grant, ram_start}, 0);
   endtask

   // Predicts the winner from the request pattern and a running loss count, then runs the burst.
   task automatic run(input bit r0, input bit r1, input int force_p,
                      input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                      input bit w0, input bit w1, input int l0, input int l1,
                      input int gap_max, input bit extra, input int hold);
      int p, wn;
      p = (r1 && (!r0 || model_wait >= MAX_WAIT)) ? 1 : 0;
      if (force_p >= 0) p = force_p;
      if (p == 1) model_wait = 0;
      else if (r1 && model_wait < 255) model_wait++;
      rq0_req = r0; rq1_req = r1;
      rq0_addr = a0; rq1_addr = a1;
      rq0_wr = w0; rq1_wr = w1;
      rq0_len = 8'(l0); rq1_len = 8'(l1);
      do_burst(p, (p != 0) ? a1 : a0, (p != 0) ? w1 : w0, (p != 0) ? l1 : l0, gap_max, extra, hold, wn);
   endtask

   initial begin
      #500000;
      failures++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      int wn, n;
      bit r0, r1;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_grant", {rq0_grant, rq1_grant}, 0);
      check_eq("rst_ram_ctl", {ram_start, ram_stop, ram_wr}, 0);
      check_eq("rst_ram_addr", ram_addr, 0);
      check_eq("rst_ram_wdata", ram_wdata, 0);
      check_eq("rst_rq_status", {rq0_wready, rq0_rvalid, rq0_done, rq1_wready, rq1_rvalid, rq1_done}, 0);
      check_eq("rst_rdata", {rq0_rdata, rq1_rdata}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      fixed_data = 1'b1;
      run(1'b1, 1'b0, -1, 24'h000123, 24'h000000, 1'b0, 1'b0, 0, 0, 1, 1'b0, 1);
      run(1'b0, 1'b1, -1, 24'h000000, 24'h00ABCD, 1'b0, 1'b1, 0, 3, 1, 1'b1, 2);
      fixed_data = 1'b0;

      // both ports requesting continuously: eight wins for port 0, one for port 1, then port 0
      for (int k = 0; k < 10; k++)
         run(1'b1, 1'b1, (k == 8) ? 1 : 0, 24'($urandom), 24'($urandom), 1'($urandom), 1'($urandom),
             $urandom_range(2, 0), $urandom_range(2, 0), 1, 1'b0, $urandom_range(2, 0));

      ram_busy = 1'b1;
      rq0_req = 1'b1; rq1_req = 1'b0;
      rq0_wr = 1'b0; rq0_len = 8'd1; rq0_addr = 24'h003344;
      for (int k = 0; k < 4; k++) begin
         next_cyc();
         @(negedge clk);
         check_eq("busy_gate", rq0_grant | rq1_grant | ram_start, 0);
      end
      ram_busy = 1'b0;
      do_burst(0, 24'h003344, 1'b0, 1, 1, 1'b0, 0, wn);
      check_eq("busy_release_latency", wn, 0);

      run(1'b1, 1'b0, -1, 24'h7FFF00, 24'h0, 1'b0, 1'b0, 255, 0, 0, 1'b1, 1);

      for (int k = 0; k < 40; k++) begin
         r0 = 1'($urandom);
         r1 = 1'($urandom);
         if (!r0 && !r1) r1 = 1'b1;
         run(r0, r1, -1, 24'($urandom), 24'($urandom), 1'($urandom), 1'($urandom),
             $urandom_range(7, 0), $urandom_range(7, 0), 2, 1'($urandom), $urandom_range(3, 0));
      end

      rq0_req = 1'b1; rq1_req = 1'b0;
      rq0_wr = 1'b0; rq0_len = 8'd20; rq0_addr = 24'h0F0F0F;
      n = 0;
      @(negedge clk);
      while (!rq0_grant && n < 40) begin
         next_cyc();
         @(negedge clk);
         n++;
      end
      check_eq("rst_test_grant", rq0_grant, 1);
      next_cyc();
      ram_busy = 1'b1;
      ram_rvalid = 1'b1;
      ram_rdata = 8'hC3;
      repeat (3) next_cyc();
      @(negedge clk);
      check_eq("pre_rst_rvalid", rq0_rvalid, 1);
      rst_n = 1'b0;
      #1;
      check_eq("midrst_grant", {rq0_grant, rq1_grant}, 0);
      check_eq("midrst_ram_ctl", {ram_start, ram_stop, ram_wr}, 0);
      check_eq("midrst_ram_addr", ram_addr, 0);
      check_eq("midrst_ram_wdata", ram_wdata, 0);
      check_eq("midrst_rq_status", {rq0_wready, rq0_rvalid, rq0_done, rq1_wready, rq1_rvalid, rq1_done}, 0);
      check_eq("midrst_rdata", {rq0_rdata, rq1_rdata}, 0);
      ram_busy = 1'b0;
      ram_rvalid = 1'b0;
      rq0_req = 1'b0; rq1_req = 1'b1;
      rq1_wr = 1'b1; rq1_len = 8'd2; rq1_addr = 24'h00BEEF;
      for (int k = 0; k < 3; k++) begin
         next_cyc();
         check_eq("no_done_in_rst", rq0_done | rq1_done | rq0_grant | rq1_grant, 0);
      end
      rst_n = 1'b1;
      model_wait = 0;
      do_burst(1, 24'h00BEEF, 1'b1, 2, 1, 1'b0, 1, wn);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
